// File: rtl/fir_tap_sequencer.sv
// Input-side sequencer for the serial-MAC FIR: buffers one sample per frame in a circular delay line and
// streams NTAPS (sample, coefficient) pairs to the MAC. Define COEF_LOAD_EN for a writable coefficient file.
module fir_tap_sequencer #(
  parameter int NTAPS = 8,
  parameter int DW    = 20,
  parameter int CW    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DW-1:0]             in_sample,
  output logic                      in_ready,
  output logic                      tap_valid,
  output logic                      tap_first,
  output logic                      tap_last,
  output logic [DW-1:0]             tap_sample,
  output logic [CW-1:0]             tap_coef
`ifdef COEF_LOAD_EN
  ,
  input  logic                      coef_we,
  input  logic [$clog2(NTAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]             coef_wdata,
  output logic                      coef_drop
`endif
);

  localparam int AW = $clog2(NTAPS);
  localparam logic [CW-1:0] DEFAULT_COEF = CW'(1 << (CW - 4));

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [AW-1:0] k;        // index of the next tap to issue
  logic [AW-1:0] wr_ptr;   // slot of the newest sample in the current frame
  logic [DW-1:0] mem [NTAPS];

  logic          accept;
  logic          frame_end;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] tap_idx;
  logic [CW-1:0] coef_sel;

  // A new frame may start from IDLE or, with no bubble, from the tap_last cycle.
  assign in_ready  = ~reset & ((state == IDLE) | tap_last);
  assign accept    = in_valid & in_ready;
  assign frame_end = (state == RUN) & tap_last;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    wr_addr = wr_ptr;
    if (state == RUN) wr_addr = wr_ptr + AW'(1);
    rd_addr = wr_ptr - k;
    tap_idx = accept ? '0 : k;
  end

`ifdef COEF_LOAD_EN
  logic [CW-1:0] h [NTAPS];

  assign coef_sel = h[tap_idx];

  // Writes only land while the MAC is idle so a frame never sees mixed coefficient sets.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) h[i] <= DEFAULT_COEF;
      coef_drop <= 1'b0;
    end else begin
      coef_drop <= 1'b0;
      if (coef_we) begin
        if (state == IDLE && !accept) h[coef_addr] <= coef_wdata;
        else                          coef_drop    <= 1'b1;
      end
    end
  end
`else
  logic unused_idx;
  assign unused_idx = ^tap_idx;
  assign coef_sel   = DEFAULT_COEF;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      k          <= '0;
      wr_ptr     <= '0;
      tap_valid  <= 1'b0;
      tap_first  <= 1'b0;
      tap_last   <= 1'b0;
      tap_sample <= '0;
      tap_coef   <= '0;
      // NOTE: the delay line is cleared on reset so a fresh stream sees x[n-k]=0 for history.
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else if (accept) begin
      // Tap 0 is the incoming sample itself, bypassed straight to the output.
      mem[wr_addr] <= in_sample;
      wr_ptr       <= wr_addr;
      state        <= RUN;
      k            <= AW'(1);
      tap_valid    <= 1'b1;
      tap_first    <= 1'b1;
      tap_last     <= 1'b0;
      tap_sample   <= in_sample;
      tap_coef     <= coef_sel;
    end else if (frame_end) begin
      wr_ptr     <= wr_ptr + AW'(1);
      state      <= IDLE;
      k          <= '0;
      tap_valid  <= 1'b0;
      tap_first  <= 1'b0;
      tap_last   <= 1'b0;
      tap_sample <= '0;
      tap_coef   <= '0;
    end else if (state == RUN) begin
      tap_sample <= mem[rd_addr];
      tap_coef   <= coef_sel;
      tap_first  <= 1'b0;
      tap_last   <= (k == AW'(NTAPS - 1));
      k          <= k + AW'(1);
    end
  end

endmodule
